rx_frame_buffer: RTL

//  Store-and-forward frame buffer directly downstream of the Rx MAC AXIS output, which has no tready.

---
 rtl/rx_frame_buffer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer
//   Store-and-forward buffer behind an Rx MAC AXIS output that cannot be stalled.
//   Beats are staged for one cycle, written into a circular RAM, and a frame only becomes
//   visible to the reader once its tlast beat arrives with tuser=1. Bad-CRC, empty,
//   and overflowing frames are rewound out of the RAM. The output side adds tready
//   backpressure through a two-stage prefetch (RAM read register + output register).
// Ports
//   i_clk, i_reset           clock, async active-high reset
//   s00_axis_*               input beats (no tready); tuser = CRC good on tlast
//   m00_axis_*               output frames with tready backpressure
//   o_frames_ok/bad/ovf      wrapping per-cause frame counters
module rx_frame_buffer #(
    parameter int DEPTH_WORDS = 512,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [31:0]          s00_axis_tdata,
    input  logic [3:0]           s00_axis_tkeep,
    input  logic                 s00_axis_tvalid,
    input  logic                 s00_axis_tlast,
    input  logic                 s00_axis_tuser,
    output logic [31:0]          m00_axis_tdata,
    output logic [3:0]           m00_axis_tkeep,
    output logic                 m00_axis_tvalid,
    input  logic                 m00_axis_tready,
    output logic                 m00_axis_tlast,
    output logic [CNT_WIDTH-1:0] o_frames_ok,
    output logic [CNT_WIDTH-1:0] o_frames_bad,
    output logic [CNT_WIDTH-1:0] o_frames_ovf
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW:0]          FULL_LVL = (AW+1)'(DEPTH_WORDS);
    localparam logic [AW:0]          PTR_ONE  = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

    // RAM word = {last, keep[3:0], data[31:0]}
    logic [36:0] mem [DEPTH_WORDS];
    logic [36:0] ram_q;

    state_t      state;
    logic [AW:0] wr_ptr, commit_ptr, rd_ptr;
    logic        held_vld;
    logic [31:0] held_data;
    logic [3:0]  held_keep;
    logic        flush_q, flush_user;

    logic full, in_last, wr_due, wr_last, frame_end, end_user;
    logic s1_vld, out_pop, out_load, rd_en;

    assign full    = (wr_ptr - rd_ptr) == FULL_LVL;
    assign in_last = s00_axis_tvalid && s00_axis_tlast;

    // Every RAM write is the held beat; what changes per cycle is whether a write is
    // due, whether it closes the frame, and which tuser decides its fate.
    always_comb begin
        wr_due    = 1'b0;
        wr_last   = 1'b0;
        frame_end = 1'b0;
        end_user  = 1'b0;
        if (state != S_DROP) begin
            if (flush_q) begin
                wr_due    = 1'b1;
                wr_last   = 1'b1;
                frame_end = 1'b1;
                end_user  = flush_user;
            end else if (s00_axis_tvalid) begin
                wr_due = held_vld;
                if (s00_axis_tlast && s00_axis_tkeep == 4'd0) begin
                    // Zero-keep terminator: held beat becomes the last word, no extra word.
                    wr_last   = held_vld;
                    frame_end = 1'b1;
                    end_user  = s00_axis_tuser;
                end
            end
        end
    end

    // Write-side state, staging and counters
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            held_vld     <= 1'b0;
            held_data    <= '0;
            held_keep    <= '0;
            flush_q      <= 1'b0;
            flush_user   <= 1'b0;
            o_frames_ok  <= '0;
            o_frames_bad <= '0;
            o_frames_ovf <= '0;
        end else if (state == S_DROP) begin
            if (in_last) begin
                o_frames_ovf <= o_frames_ovf + CNT_ONE;
                state        <= S_IDLE;
            end
        end else if (wr_due && full) begin
            // Rewind to the last commit; the frame is only counted once its end is seen.
            wr_ptr   <= commit_ptr;
            held_vld <= 1'b0;
            flush_q  <= 1'b0;
            if (flush_q || in_last) begin
                o_frames_ovf <= o_frames_ovf + CNT_ONE;
                state        <= S_IDLE;
            end else begin
                state <= S_DROP;
            end
        end else begin
            if (wr_due)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (frame_end) begin
                state    <= S_IDLE;
                held_vld <= 1'b0;
                flush_q  <= 1'b0;
                if (!wr_due) begin
                    o_frames_bad <= o_frames_bad + CNT_ONE;   // empty frame
                end else if (end_user) begin
                    commit_ptr  <= wr_ptr + PTR_ONE;
                    o_frames_ok <= o_frames_ok + CNT_ONE;
                end else begin
                    wr_ptr       <= commit_ptr;               // overrides the advance above
                    o_frames_bad <= o_frames_bad + CNT_ONE;
                end
            end else if (s00_axis_tvalid) begin
                state      <= S_RECV;
                held_vld   <= 1'b1;
                held_data  <= s00_axis_tdata;
                held_keep  <= s00_axis_tkeep;
                flush_q    <= s00_axis_tlast;                 // non-zero-keep tlast flushes next cycle
                flush_user <= s00_axis_tuser;
            end
        end
    end

    // Read pipeline: RAM read register (s1) feeding the output register.
    assign out_pop  = m00_axis_tvalid && m00_axis_tready;
    assign out_load = s1_vld && (!m00_axis_tvalid || out_pop);
    assign rd_en    = (rd_ptr != commit_ptr) && (!s1_vld || out_load);

    always_ff @(posedge i_clk) begin
        if (wr_due && !full)
            mem[wr_ptr[AW-1:0]] <= {wr_last, held_keep, held_data};
        if (rd_en)
            ram_q <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_ptr          <= '0;
            s1_vld          <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tkeep  <= '0;
            m00_axis_tdata  <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                s1_vld <= 1'b1;
            end else if (out_load) begin
                s1_vld <= 1'b0;
            end
            if (out_load) begin
                {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata} <= ram_q;
                m00_axis_tvalid <= 1'b1;
            end else if (out_pop) begin
                m00_axis_tvalid <= 1'b0;
            end
        end
    end

    // Upstream must leave the flush cycle free of beats.
    a_no_beat_in_flush: assert property (@(posedge i_clk) disable iff (i_reset)
        flush_q |-> !s00_axis_tvalid);

endmodule
